// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// One 33-bit adder/subtractor is stepped 32 times (one result bit per
// cycle), followed by a single sign-fixup cycle that writes HI/LO.
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   start_i, op_i       launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), IDLE only
//   a_i, b_i            rs / rt operands, sampled with start_i
//   cancel_i            abort any in-flight operation, drop a same-cycle start
//   mthi_i, mtlo_i      write wdata_i to HI / LO (IDLE only)
//   wdata_i             MTHI/MTLO data
//   busy_o              high while not IDLE
//   done_o              one-cycle pulse when HI/LO take a result
//   hi_o, lo_o          HI / LO registers
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath working registers.
  logic [31:0] acc_q, acc_d;       // product upper half / remainder
  logic [31:0] work_q, work_d;     // multiplier -> product low / dividend -> quotient
  logic [31:0] opb_q, opb_d;       // multiplicand / divisor magnitude
  logic [31:0] araw_q, araw_d;     // original a_i, HI result on divide by zero
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        neg_res_q, neg_res_d;  // operand signs differ (signed ops)
  logic        neg_rem_q, neg_rem_d;  // dividend negative (signed ops)
  logic        dz_q, dz_d;            // divide by zero

  logic        in_signed;
  logic [31:0] a_mag, b_mag;
  logic        is_div;
  logic [32:0] add_x, add_y, add_res;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Operand magnitudes for the incoming request.
  always_comb begin
    in_signed = ~op_i[0];
    a_mag     = (in_signed && a_i[31]) ? 32'd0 - a_i : a_i;
    b_mag     = (in_signed && b_i[31]) ? 32'd0 - b_i : b_i;
  end

  // The single shared adder: add for multiply, subtract for divide.
  // Divide shifts the remainder left and brings in the dividend MSB; since the
  // remainder is always below the divisor, bit 32 of the difference is a
  // reliable borrow.
  always_comb begin
    is_div  = op_q[1];
    add_x   = is_div ? {acc_q, work_q[31]} : {1'b0, acc_q};
    add_y   = {1'b0, opb_q};
    add_res = add_x + (add_y ^ {33{is_div}}) + {32'd0, is_div};
    mul_sum = work_q[0] ? add_res : {1'b0, acc_q};
  end

  // Sign fixup, used only in SIGN.
  always_comb begin
    prod_fix = {acc_q, work_q};
    if (!is_div && neg_res_q) prod_fix = 64'd0 - {acc_q, work_q};
    quot_fix = neg_res_q ? 32'd0 - work_q : work_q;
    rem_fix  = neg_rem_q ? 32'd0 - acc_q : acc_q;
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opb_d     = opb_q;
    araw_d    = araw_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;

    unique case (state_q)
      IDLE: begin
        if (mthi_i) hi_d = wdata_i;
        if (mtlo_i) lo_d = wdata_i;
        if (start_i && !cancel_i) begin
          op_d      = op_i;
          acc_d     = 32'd0;
          work_d    = op_i[1] ? a_mag : b_mag;
          opb_d     = op_i[1] ? b_mag : a_mag;
          araw_d    = a_i;
          neg_res_d = in_signed & (a_i[31] ^ b_i[31]);
          neg_rem_d = in_signed & a_i[31];
          dz_d      = op_i[1] & (b_i == 32'd0);
          cnt_d     = 6'd0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (cancel_i) begin
          state_d = IDLE;
        end else begin
          if (is_div) begin
            acc_d  = add_res[32] ? add_x[31:0] : add_res[31:0];
            work_d = {work_q[30:0], ~add_res[32]};
          end else begin
            acc_d  = mul_sum[32:1];
            work_d = {mul_sum[0], work_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = SIGN;
        end
      end
      SIGN: begin
        if (!cancel_i) begin
          if (!is_div) begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end else if (dz_q) begin
            hi_d = araw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
          done_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: the datapath registers carry no reset; every one is loaded when a
  // start is accepted, before anything reads it.
  always_ff @(posedge clk_i) begin
    acc_q     <= acc_d;
    work_q    <= work_d;
    opb_q     <= opb_d;
    araw_q    <= araw_d;
    cnt_q     <= cnt_d;
    op_q      <= op_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a cycle-level behavioural model
// (countdown timer + plain arithmetic) checked every cycle, plus directed
// vectors with hand-computed HI/LO, latency and handshake expectations.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        cancel_i = 1'b0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .cancel_i(cancel_i), .mthi_i(mthi_i),
    .mtlo_i(mtlo_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, v, vq, vr;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    v  = 64'd0;
    case (op)
      OP_MULT:  begin sq = sa * sb; v = sq; end
      OP_MULTU: v = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) v = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          vq = sq; vr = sr;
          v = {vr[31:0], vq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) v = {a, 32'hFFFF_FFFF};
        else v = {a % b, a / b};
      end
    endcase
    return v;
  endfunction

  // Cycle model: an accepted start completes 33 edges later unless cancelled.
  int          m_rem = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (cancel_i) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end else begin
        if (mthi_i) m_hi = wdata_i;
        if (mtlo_i) m_lo = wdata_i;
        if (start_i && !cancel_i) begin
          m_pend = ref_result(op_i, a_i, b_i);
          m_rem  = 33;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    check("busy", {63'd0, busy_o}, {63'd0, (m_rem > 0)});
    check("done", {63'd0, done_o}, {63'd0, m_done});
    check("hi",   {32'd0, hi_o},   {32'd0, m_hi});
    check("lo",   {32'd0, lo_o},   {32'd0, m_lo});
  end

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Returns at the negedge where done_o is seen (or at the bound).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy_o ? 1 : 0;
    while (!done_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
      if (busy_o) busy_cnt++;
    end
    if (!done_o) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat, bc;
    start_op(op, a, b);
    wait_done(lat, bc);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_cycles"}, 64'(bc), 64'd33);
    check({name, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
    check({name, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic saw_done;
    int   lat, bc;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_hi",   {32'd0, hi_o},   64'd0);
    check("rst_lo",   {32'd0, lo_o},   64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Pin the model itself to hand-computed values.
    check("model_multu", ref_result(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("model_div_ovf", ref_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("model_div_neg", ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    // Back-to-back chain: each start is raised in the previous done cycle.
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_m3x7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mult_min2", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("div_m7d2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu_100d7", OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
    do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    do_op("divu_dz",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    do_op("div_dz",    OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // MTHI / MTLO land on the next edge.
    mthi_i = 1'b1; wdata_i = 32'h0000_1234;
    @(negedge clk_i);
    mthi_i = 1'b0;
    check("mthi", {32'd0, hi_o}, 64'h1234);
    mtlo_i = 1'b1; wdata_i = 32'h0000_5678;
    @(negedge clk_i);
    mtlo_i = 1'b0;
    check("mtlo", {32'd0, lo_o}, 64'h5678);

    // Start while busy and MTHI while busy are ignored; cancel at E10.
    start_op(OP_MULTU, 32'd3, 32'd4);               // now just after E0
    repeat (4) @(negedge clk_i);                    // just after E4
    op_i = OP_MULTU; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    mthi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mthi_i = 1'b0;
    repeat (3) @(negedge clk_i);                    // just after E9
    cancel_i = 1'b1;
    @(negedge clk_i);
    cancel_i = 1'b0;
    check("cancel_busy", {63'd0, busy_o}, 64'd0);
    check("cancel_hi", {32'd0, hi_o}, 64'h1234);
    check("cancel_lo", {32'd0, lo_o}, 64'h5678);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    check("cancel_no_done", {63'd0, saw_done}, 64'd0);

    // Start together with cancel in IDLE is dropped.
    op_i = OP_MULTU; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; cancel_i = 1'b0;
    check("start_cancel_dropped", {63'd0, busy_o}, 64'd0);

    // MTHI together with start: move lands now, result overwrites later.
    mthi_i = 1'b1; wdata_i = 32'hCAFE_0000;
    start_op(OP_MULTU, 32'd5, 32'd5);
    mthi_i = 1'b0;
    check("mthi_with_start", {32'd0, hi_o}, 64'hCAFE_0000);
    wait_done(lat, bc);
    check("mthi_start_lat", 64'(lat), 64'd33);
    check("mthi_start_hi", {32'd0, hi_o}, 64'd0);
    check("mthi_start_lo", {32'd0, lo_o}, 64'd25);

    // Reset in the middle of a DIVU, then a clean MULTU.
    start_op(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk_i);                   // just after E19
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_hi", {32'd0, hi_o}, 64'd0);
    check("midrst_lo", {32'd0, lo_o}, 64'd0);
    rst_ni = 1'b1;
    do_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
